time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/clock_ctrl_pkg.sv | 44 ++++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/time_set_controller.sv | 169 ++++++++++++++++
 tb/tb_time_set_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock time-set controller: FSM states, field_sel encoding,
// and small decode helpers used by the top level.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StSetHh = 2'd1,
        StSetMm = 2'd2,
        StSetSs = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;
    localparam logic [1:0] FIELD_SS   = 2'd3;

    // Order of fields walked by the select button; SS wraps back to RUN.
    function automatic state_e next_set_state(state_e st);
        case (st)
            StSetHh: return StSetMm;
            StSetMm: return StSetSs;
            default: return StRun;
        endcase
    endfunction

    function automatic logic [1:0] field_of(state_e st);
        case (st)
            StSetHh: return FIELD_HH;
            StSetMm: return FIELD_MM;
            StSetSs: return FIELD_SS;
            default: return FIELD_NONE;
        endcase
    endfunction

    function automatic logic [5:0] blink_pattern(state_e st, logic ph);
        case (st)
            StSetHh: return {ph, ph, 4'b0000};
            StSetMm: return {2'b00, ph, ph, 2'b00};
            StSetSs: return {4'b0000, ph, ph};
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus optional stable-count filter for one raw button.
// Filter present only when DEBOUNCE_EN is defined; otherwise the synchronizer output is used.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic released
);

    logic       sync1_q, sync2_q;
    logic [1:0] settle_q;

    if (DEBOUNCE_CYC < 1) begin : g_param_check
        $error("btn_debounce: DEBOUNCE_CYC must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

    logic [CntW-1:0] cnt_q;
    logic            level_q;

    // Level follows the synchronized input only after DEBOUNCE_CYC consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync2_q == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    // True once the synchronizer holds real samples and the button is seen up.
    assign released = settle_q[1] & ~sync2_q & ~level;

endmodule

// File: rtl/time_set_controller.sv
// Two-button time-set controller: press classification, RUN/SET FSM, idle timeout and blink.
// Define DEBOUNCE_EN to insert the stable-count filter in each button path.
module time_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned DEBOUNCE_CYC   = 500000,
    parameter int unsigned LONG_PRESS_CYC = 25000000,
    parameter int unsigned BLINK_HALF_CYC = 12500000,
    parameter int unsigned SET_TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button1,
    input  logic       button2,
    input  logic       tick_1hz,
    output logic       cnt_tick,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [1:0] field_sel,
    output logic [5:0] blink_mask,
    output logic       set_mode
);

    localparam int unsigned HoldW  = $clog2(LONG_PRESS_CYC + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_HALF_CYC + 1);
    localparam int unsigned TmoW   = $clog2(SET_TIMEOUT_S + 1);

    if (CLK_HZ == 0 || LONG_PRESS_CYC < 2 || BLINK_HALF_CYC < 1 || SET_TIMEOUT_S < 1)
    begin : g_param_check
        $error("time_set_controller: parameter out of range");
    end

    logic [1:0]       lvl, released;
    logic [HoldW-1:0] hold_q [2];
    logic [HoldW-1:0] hold_d [2];
    logic [1:0]       armed_q, armed_d;
    logic             void_q, void_d;
    logic             chord;
    logic [1:0]       long_evt, short_evt;
    logic             any_evt, in_set, timeout;

    state_e            state_q, state_d;
    logic [TmoW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              ph_q, ph_d;
    logic              cnt_tick_d, inc_d, dec_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_b1 (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (button1),
        .level    (lvl[0]),
        .released (released[0])
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_b2 (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (button2),
        .level    (lvl[1]),
        .released (released[1])
    );

    // A press only counts once the button has been seen up since reset (discards held presses).
    always_comb begin
        chord = lvl[0] & lvl[1];
        for (int i = 0; i < 2; i++) begin
            if (!lvl[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] == HoldW'(LONG_PRESS_CYC)) begin
                hold_d[i] = hold_q[i];
            end else begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
            long_evt[i]  = armed_q[i] & ~void_q & ~chord & lvl[i] &
                           (hold_q[i] == HoldW'(LONG_PRESS_CYC - 1));
            short_evt[i] = armed_q[i] & ~void_q & ~lvl[i] & (hold_q[i] != '0) &
                           (hold_q[i] != HoldW'(LONG_PRESS_CYC));
            armed_d[i]   = armed_q[i] | released[i];
        end
        void_d  = chord | (void_q & (lvl[0] | lvl[1]));
        any_evt = |{long_evt, short_evt};
    end

    always_comb begin
        in_set  = (state_q != StRun);
        timeout = in_set & tick_1hz & ~any_evt & (idle_cnt_q == TmoW'(SET_TIMEOUT_S - 1));
        if (!in_set || any_evt || timeout) begin
            idle_cnt_d = '0;
        end else if (tick_1hz) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (long_evt[0]) state_d = StSetHh;
            end
            default: begin
                if (long_evt[0]) begin
                    state_d = next_set_state(state_q);
                end else if (long_evt[1] || timeout) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    always_comb begin
        set_mode   = in_set;
        field_sel  = field_of(state_q);
        blink_mask = blink_pattern(state_q, ph_q);
        cnt_tick_d = tick_1hz & ~in_set;
        inc_d      = in_set & short_evt[0];
        dec_d      = in_set & short_evt[1] & ~short_evt[0];
    end

    // Phase restarts visible on every SET entry and every edit pulse.
    always_comb begin
        if (!in_set || inc_d || dec_d || (state_d != StRun && state_d != state_q)) begin
            blink_cnt_d = '0;
            ph_d        = 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_HALF_CYC - 1)) begin
            blink_cnt_d = '0;
            ph_d        = ~ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            ph_d        = ph_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) hold_q[i] <= '0;
            armed_q     <= 2'b00;
            void_q      <= 1'b0;
            idle_cnt_q  <= '0;
            blink_cnt_q <= '0;
            ph_q        <= 1'b0;
            cnt_tick    <= 1'b0;
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) hold_q[i] <= hold_d[i];
            armed_q     <= armed_d;
            void_q      <= void_d;
            idle_cnt_q  <= idle_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            ph_q        <= ph_d;
            cnt_tick    <= cnt_tick_d;
            inc_pulse   <= inc_d;
            dec_pulse   <= dec_d;
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short timing parameters (default build,
// no debounce filter): run ticks, SET entry/blink, edits, chords, timeout, reset mid-press.
module tb_time_set_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       button1, button2, tick_1hz;
    logic       cnt_tick, inc_pulse, dec_pulse, set_mode;
    logic [1:0] field_sel;
    logic [5:0] blink_mask;

    int compared   = 0;
    int mismatched = 0;
    int inc_seen   = 0;
    int dec_seen   = 0;
    int multi_hot  = 0;
    logic [1:0] last_inc_field = 2'd0;
    logic [1:0] last_dec_field = 2'd0;

    time_set_controller #(
        .DEBOUNCE_CYC   (4),
        .LONG_PRESS_CYC (20),
        .BLINK_HALF_CYC (8),
        .SET_TIMEOUT_S  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button1    (button1),
        .button2    (button2),
        .tick_1hz   (tick_1hz),
        .cnt_tick   (cnt_tick),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .field_sel  (field_sel),
        .blink_mask (blink_mask),
        .set_mode   (set_mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inc_pulse) begin
            inc_seen++;
            last_inc_field = field_sel;
        end
        if (dec_pulse) begin
            dec_seen++;
            last_dec_field = field_sel;
        end
        if (int'(cnt_tick) + int'(inc_pulse) + int'(dec_pulse) > 1) multi_hot++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic long_press_b1();
        button1 = 1'b1;
        repeat (30) step();
        button1 = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        button1 = 1'b0;
        button2 = 1'b0;
        tick_1hz = 1'b0;
        repeat (3) step();
        compared++; if (cnt_tick !== 1'b0) begin mismatched++;
            $display("FAIL reset_cnt_tick: got %b want 0", cnt_tick); end
        compared++; if (inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin mismatched++;
            $display("FAIL reset_pulses: got inc=%b dec=%b want 0 0", inc_pulse, dec_pulse); end
        compared++; if (set_mode !== 1'b0) begin mismatched++;
            $display("FAIL reset_set_mode: got %b want 0", set_mode); end
        compared++; if (field_sel !== 2'd0) begin mismatched++;
            $display("FAIL reset_field_sel: got %0d want 0", field_sel); end
        compared++; if (blink_mask !== 6'b000000) begin mismatched++;
            $display("FAIL reset_blink_mask: got %b want 000000", blink_mask); end
        reset = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_run_ticks();
        int inc0 = inc_seen;
        int dec0 = dec_seen;
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1;
            compared++; if (cnt_tick !== 1'b0) begin mismatched++;
                $display("FAIL run_tick_early[%0d]: got %b want 0", i, cnt_tick); end
            step();
            tick_1hz = 1'b0;
            compared++; if (cnt_tick !== 1'b1) begin mismatched++;
                $display("FAIL run_tick_latency[%0d]: got %b want 1", i, cnt_tick); end
            step();
            compared++; if (cnt_tick !== 1'b0) begin mismatched++;
                $display("FAIL run_tick_width[%0d]: got %b want 0", i, cnt_tick); end
            step();
        end
        compared++; if (inc_seen != inc0 || dec_seen != dec0) begin mismatched++;
            $display("FAIL run_no_edits: got inc=%0d dec=%0d want 0 0",
                     inc_seen - inc0, dec_seen - dec0); end
    endtask

    task automatic test_enter_set();
        int inc0 = inc_seen;
        button1 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 30) button1 = 1'b0;
            if (k == 21) begin
                compared++; if (set_mode !== 1'b0) begin mismatched++;
                    $display("FAIL enter_before_long: got set_mode=%b want 0", set_mode); end
            end
            if (k == 22) begin
                compared++; if (set_mode !== 1'b1 || field_sel !== 2'd1) begin mismatched++;
                    $display("FAIL enter_set_hh: got mode=%b field=%0d want 1 1",
                             set_mode, field_sel); end
            end
            if (k == 22 || k == 29 || k == 38) begin
                compared++; if (blink_mask !== 6'b000000) begin mismatched++;
                    $display("FAIL blink_hh_off[k=%0d]: got %b want 000000", k, blink_mask); end
            end
            if (k == 30 || k == 37) begin
                compared++; if (blink_mask !== 6'b110000) begin mismatched++;
                    $display("FAIL blink_hh_on[k=%0d]: got %b want 110000", k, blink_mask); end
            end
        end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        compared++; if (cnt_tick !== 1'b0) begin mismatched++;
            $display("FAIL set_tick_dropped: got %b want 0", cnt_tick); end
        compared++; if (inc_seen != inc0) begin mismatched++;
            $display("FAIL long_no_inc: got %0d inc want 0", inc_seen - inc0); end
        repeat (3) step();
    endtask

    task automatic test_inc_mm();
        int inc0 = inc_seen;
        button1 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 30) button1 = 1'b0;
            if (k == 37) button1 = 1'b1;
            if (k == 47) button1 = 1'b0;
            if (k == 22) begin
                compared++; if (field_sel !== 2'd2) begin mismatched++;
                    $display("FAIL advance_mm: got field=%0d want 2", field_sel); end
            end
            if (k == 49) begin
                compared++; if (blink_mask !== 6'b001100 || inc_pulse !== 1'b0) begin
                    mismatched++;
                    $display("FAIL mm_before_inc: got mask=%b inc=%b want 001100 0",
                             blink_mask, inc_pulse); end
            end
            if (k == 50) begin
                compared++; if (inc_pulse !== 1'b1 || field_sel !== 2'd2) begin mismatched++;
                    $display("FAIL mm_inc: got inc=%b field=%0d want 1 2",
                             inc_pulse, field_sel); end
                compared++; if (blink_mask !== 6'b000000) begin mismatched++;
                    $display("FAIL mm_inc_visible: got %b want 000000", blink_mask); end
            end
            if (k == 51) begin
                compared++; if (inc_pulse !== 1'b0) begin mismatched++;
                    $display("FAIL mm_inc_width: got %b want 0", inc_pulse); end
            end
            if (k == 53) begin
                compared++; if (blink_mask !== 6'b000000) begin mismatched++;
                    $display("FAIL mm_phase_restart: got %b want 000000", blink_mask); end
            end
        end
        compared++; if (inc_seen - inc0 != 1) begin mismatched++;
            $display("FAIL mm_inc_count: got %0d want 1", inc_seen - inc0); end
    endtask

    task automatic test_chord();
        int inc0 = inc_seen;
        int dec0 = dec_seen;
        button1 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 3) button2 = 1'b1;
            if (k == 8) button1 = 1'b0;
            if (k == 12) button2 = 1'b0;
        end
        compared++; if (inc_seen != inc0 || dec_seen != dec0) begin mismatched++;
            $display("FAIL chord_voided: got inc=%0d dec=%0d want 0 0",
                     inc_seen - inc0, dec_seen - dec0); end
        compared++; if (set_mode !== 1'b1 || field_sel !== 2'd2) begin mismatched++;
            $display("FAIL chord_state: got mode=%b field=%0d want 1 2", set_mode, field_sel); end
        button2 = 1'b1;
        repeat (5) step();
        button2 = 1'b0;
        repeat (8) step();
        compared++; if (dec_seen - dec0 != 1 || last_dec_field !== 2'd2) begin mismatched++;
            $display("FAIL after_chord_dec: got count=%0d field=%0d want 1 2",
                     dec_seen - dec0, last_dec_field); end
        compared++; if (inc_seen != inc0) begin mismatched++;
            $display("FAIL after_chord_inc: got %0d want 0", inc_seen - inc0); end
    endtask

    task automatic test_timeout();
        long_press_b1();
        compared++; if (field_sel !== 2'd3) begin mismatched++;
            $display("FAIL advance_ss: got field=%0d want 3", field_sel); end
        for (int n = 1; n <= 3; n++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            compared++; if (cnt_tick !== 1'b0) begin mismatched++;
                $display("FAIL timeout_tick_dropped[%0d]: got %b want 0", n, cnt_tick); end
            compared++; if (set_mode !== (n < 3)) begin mismatched++;
                $display("FAIL timeout_mode[%0d]: got %b want %b", n, set_mode, n < 3); end
            repeat (3) step();
        end
        compared++; if (field_sel !== 2'd0 || blink_mask !== 6'b000000) begin mismatched++;
            $display("FAIL timeout_outputs: got field=%0d mask=%b want 0 000000",
                     field_sel, blink_mask); end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        compared++; if (cnt_tick !== 1'b1) begin mismatched++;
            $display("FAIL timeout_fourth_tick: got %b want 1", cnt_tick); end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_press();
        int inc0;
        int dec0;
        long_press_b1();
        compared++; if (set_mode !== 1'b1 || field_sel !== 2'd1) begin mismatched++;
            $display("FAIL pre_reset_set_hh: got mode=%b field=%0d want 1 1",
                     set_mode, field_sel); end
        inc0 = inc_seen;
        dec0 = dec_seen;
        button1 = 1'b1;
        repeat (15) step();
        reset = 1'b1;
        repeat (2) step();
        compared++; if ({cnt_tick, inc_pulse, dec_pulse, set_mode} !== 4'b0000) begin
            mismatched++;
            $display("FAIL midpress_reset_flags: got %b want 0000",
                     {cnt_tick, inc_pulse, dec_pulse, set_mode}); end
        compared++; if (field_sel !== 2'd0 || blink_mask !== 6'b000000) begin mismatched++;
            $display("FAIL midpress_reset_fields: got field=%0d mask=%b want 0 000000",
                     field_sel, blink_mask); end
        reset = 1'b0;
        repeat (35) step();
        button1 = 1'b0;
        repeat (10) step();
        compared++; if (set_mode !== 1'b0) begin mismatched++;
            $display("FAIL midpress_discard: got set_mode=%b want 0", set_mode); end
        compared++; if (inc_seen != inc0 || dec_seen != dec0) begin mismatched++;
            $display("FAIL midpress_no_event: got inc=%0d dec=%0d want 0 0",
                     inc_seen - inc0, dec_seen - dec0); end
    endtask

    task automatic test_glitch();
        int inc0;
        long_press_b1();
        compared++; if (set_mode !== 1'b1) begin mismatched++;
            $display("FAIL glitch_enter: got set_mode=%b want 1", set_mode); end
        inc0 = inc_seen;
        button1 = 1'b1;
        repeat (2) step();
        button1 = 1'b0;
        repeat (8) step();
        compared++; if (inc_seen - inc0 != 1 || last_inc_field !== 2'd1) begin mismatched++;
            $display("FAIL glitch_short: got count=%0d field=%0d want 1 1",
                     inc_seen - inc0, last_inc_field); end
    endtask

    task automatic test_exclusive();
        compared++; if (multi_hot != 0) begin mismatched++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", multi_hot); end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_enter_set();
        test_inc_mm();
        test_chord();
        test_timeout();
        test_reset_mid_press();
        test_glitch();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
